// File: rtl/axis_multilane_adc_reader.sv
// rtl/axis_multilane_adc_reader.sv - triggered multi-lane SPI ADC frame reader with AXI4-Stream output
module axis_multilane_adc_reader #(
  parameter int NUM_SDI     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int CLK_DIV     = 1,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 1,
  parameter int CS_HIGH_MIN = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  trigger,
  input  logic [NUM_SDI-1:0]    spi_sdi,
  output logic                  spi_clk,
  output logic                  spi_csn,
  output logic                  spi_sdo,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  trig_miss
);

  // SCLK periods per frame; each one shifts in NUM_SDI bits
  localparam int BITS    = DATA_WIDTH / NUM_SDI;
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD)
                         ? ((CS_SETUP > CS_HIGH_MIN) ? CS_SETUP : CS_HIGH_MIN)
                         : ((CS_HOLD > CS_HIGH_MIN) ? CS_HOLD : CS_HIGH_MIN);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam int BIT_W   = $clog2(BITS + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_HIGH_MIN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   shreg_next;
  logic                    trigger_q;
  logic                    trig_edge;
  logic                    deliver;

  assign trig_edge = trigger & ~trigger_q;
  assign busy      = (state != S_IDLE);
  assign spi_sdo   = 1'b0;

  // Last HOLD cycle: csn rises and the finished word is offered to the output register
  assign deliver   = (state == S_HOLD) && (cnt == HOLD_LAST);

  // New lanes enter at the bottom so the first-shifted bits end up in the MSBs
  generate
    if (BITS == 1) begin : g_single_beat
      assign shreg_next = spi_sdi;
    end else begin : g_multi_beat
      assign shreg_next = {shreg[DATA_WIDTH-NUM_SDI-1:0], spi_sdi};
    end
  endgenerate

  // Delayed trigger for rising-edge detection
  always_ff @(posedge aclk) begin
    if (areset) begin
      trigger_q <= 1'b0;
    end else begin
      trigger_q <= trigger;
    end
  end

  // Frame sequencer: csn setup, SCLK generation and sampling, csn hold and minimum high time
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      spi_clk   <= 1'b0;
      spi_csn   <= 1'b1;
      trig_miss <= 1'b0;
    end else begin
      trig_miss <= trig_edge && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (trig_edge) begin
            state   <= S_SETUP;
            spi_csn <= 1'b0;
            cnt     <= '0;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= S_SHIFT;
            spi_clk <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            spi_clk <= ~spi_clk;
            // Sample on the falling SCLK edge; the ADC launched this data on the rise
            if (spi_clk) begin
              shreg <= shreg_next;
              if (bit_cnt == BIT_LAST) begin
                state <= S_HOLD;
                cnt   <= '0;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state   <= S_GAP;
            spi_csn <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          spi_csn <= 1'b1;
          spi_clk <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry output register; a full register that is not drained drops the new word
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (deliver && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata  <= shreg;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set
      if (deliver && m_axis_tvalid && !m_axis_tready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
